reset_sequencer: RTL and testbench

- Parametrised power-on / soft reset sequencer for the synthesizer top level. Generalises the fixed three-output reset delay to NUM_OUT staged release outputs with per-output thresholds.
- Adds a synchronised release of the incoming reset.
- Adds a soft-reset request that re-asserts the outputs in reverse order and then re-runs the release ramp.
- Drives the staged active-low resets for codec, DSP core and MIDI/bus logic.

---
 rtl/reset_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
`timescale 1ns/1ps
// reset_sequencer
// Staged power-on / soft reset sequencer. After the incoming reset is released
// and synchronised, a ramp counter runs and each active-low reset output is
// released once the counter reaches that output's threshold. A soft request
// re-asserts the outputs from the highest index downwards, SHUT_GAP cycles
// apart, waits SHUT_GAP more cycles and then runs the release ramp again.
//
// Ports:
//   iCLK       system clock
//   iRST       asynchronous active-high reset
//   iSOFT_REQ  asynchronous soft reset request level (rising edge acts)
//   oRST_N     staged resets, 0 = hold, 1 = released
//   oDONE      all staged resets released
//   oBUSY      soft shutdown in progress
module reset_sequencer #(
  parameter int                         NUM_OUT  = 3,
  parameter int                         CNT_W    = 25,
  parameter logic [NUM_OUT*CNT_W-1:0]   THRESH   = {25'h8FFFFF, 25'h2FFFFF, 25'h1FFFFF},
  parameter int                         SHUT_GAP = 16
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSOFT_REQ,
  output logic [NUM_OUT-1:0] oRST_N,
  output logic               oDONE,
  output logic               oBUSY
);

  localparam int                GAP_W      = $clog2(SHUT_GAP + 1);
  localparam logic [GAP_W-1:0]  GAP_RELOAD = GAP_W'(SHUT_GAP - 1);
  localparam logic [CNT_W-1:0]  CNT_TOP    = THRESH[NUM_OUT*CNT_W-1 -: CNT_W];

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RAMP = 2'd1,
    S_RUN  = 2'd2,
    S_SHUT = 2'd3
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cont;
  logic [NUM_OUT-1:0] r_rst;
  logic [GAP_W-1:0]   r_gap;
  logic               r_busy;
  logic               r_rel_s0;
  logic               r_rel_s1;
  logic               r_req_s0;
  logic               r_req_s1;
  logic               r_req_d;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cont_nxt;
  logic [NUM_OUT-1:0] w_rst_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic               w_busy_nxt;
  logic [NUM_OUT-1:0] w_cross;
  logic               w_req;

  // Clear the highest-index set bit; used to pick the next output to re-assert.
  function automatic logic [NUM_OUT-1:0] f_drop_top(input logic [NUM_OUT-1:0] v);
    logic [NUM_OUT-1:0] res;
    logic               found;
    res   = v;
    found = 1'b0;
    for (int k = NUM_OUT - 1; k >= 0; k--) begin
      if (!found && v[k]) begin
        res[k] = 1'b0;
        found  = 1'b1;
      end else begin
        found  = found;
      end
    end
    return res;
  endfunction

  // Release synchroniser: shifts in 1 once iRST is low.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_rel_s0 <= 1'b0;
      r_rel_s1 <= 1'b0;
    end else begin
      r_rel_s0 <= 1'b1;
      r_rel_s1 <= r_rel_s0;
    end
  end

  // Soft request synchroniser plus edge-detect history flop.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_req_s0 <= 1'b0;
      r_req_s1 <= 1'b0;
      r_req_d  <= 1'b0;
    end else begin
      r_req_s0 <= iSOFT_REQ;
      r_req_s1 <= r_req_s0;
      r_req_d  <= r_req_s1;
    end
  end

  assign w_req = r_req_s1 & ~r_req_d;

  // Threshold match per output against the pre-edge counter value.
  always_comb begin
    w_cross = {NUM_OUT{1'b0}};
    for (int k = 0; k < NUM_OUT; k++) begin
      w_cross[k] = (r_cont == THRESH[k*CNT_W +: CNT_W]);
    end
  end

  // Next-state and datapath update for the sequencer FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cont_nxt  = r_cont;
    w_rst_nxt   = r_rst;
    w_gap_nxt   = r_gap;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_HOLD: begin
        if (r_rel_s1) begin
          w_state_nxt = S_RAMP;
          w_cont_nxt  = CNT_W'(1);
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_RAMP: begin
        if (w_req) begin
          // An output crossing on this edge counts as the first one dropped,
          // so it never pulses high.
          w_state_nxt = S_SHUT;
          w_busy_nxt  = 1'b1;
          w_rst_nxt   = f_drop_top(r_rst | w_cross);
          w_gap_nxt   = GAP_RELOAD;
        end else begin
          w_rst_nxt  = r_rst | w_cross;
          w_cont_nxt = (r_cont == CNT_TOP) ? r_cont : r_cont + CNT_W'(1);
          if (w_cross[NUM_OUT-1]) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_RAMP;
          end
        end
      end
      S_RUN: begin
        if (w_req) begin
          w_state_nxt = S_SHUT;
          w_busy_nxt  = 1'b1;
          w_rst_nxt   = f_drop_top(r_rst);
          w_gap_nxt   = GAP_RELOAD;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_SHUT: begin
        if (r_gap == {GAP_W{1'b0}}) begin
          if (|r_rst) begin
            w_rst_nxt = f_drop_top(r_rst);
            w_gap_nxt = GAP_RELOAD;
          end else begin
            // Final wait elapsed: restart the ramp from zero.
            w_state_nxt = S_RAMP;
            w_cont_nxt  = {CNT_W{1'b0}};
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_gap_nxt = r_gap - GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_HOLD;
        w_cont_nxt  = {CNT_W{1'b0}};
        w_rst_nxt   = {NUM_OUT{1'b0}};
        w_gap_nxt   = {GAP_W{1'b0}};
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state <= S_HOLD;
      r_cont  <= {CNT_W{1'b0}};
      r_rst   <= {NUM_OUT{1'b0}};
      r_gap   <= {GAP_W{1'b0}};
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cont  <= w_cont_nxt;
      r_rst   <= w_rst_nxt;
      r_gap   <= w_gap_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign oRST_N = r_rst;
  assign oDONE  = &r_rst;
  assign oBUSY  = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
`timescale 1ns/1ps
// tb_reset_sequencer
// Drives directed scenarios and a randomized soak against an event-scheduled
// reference model of the staged reset sequencer.
module tb_reset_sequencer;

  localparam int G = 3;

  logic       iCLK;
  logic       iRST;
  logic       iSOFT_REQ;
  logic [2:0] oRST_N;
  logic       oDONE;
  logic       oBUSY;

  int n_checks;
  int n_errors;

  reset_sequencer #(
    .NUM_OUT  (3),
    .CNT_W    (8),
    .THRESH   ({8'd20, 8'd8, 8'd4}),
    .SHUT_GAP (G)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iSOFT_REQ (iSOFT_REQ),
    .oRST_N    (oRST_N),
    .oDONE     (oDONE),
    .oBUSY     (oBUSY)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // ---------------- reference model ----------------
  // Edges are numbered from the release of iRST; the request edge is found
  // from the history of sampled request levels, and shutdown steps are
  // scheduled as absolute edge numbers.
  int         thr [3] = '{4, 8, 20};
  int         m_n;
  bit         m_smp [$];
  int         m_mode;   // 0 hold, 1 ramp, 2 run, 3 shutdown
  int         m_cont;
  logic [2:0] m_out;
  bit         m_busy;
  int         m_due;

  function automatic bit smp_at(int j);
    if (j >= 1 && j <= m_smp.size()) return m_smp[j-1];
    return 1'b0;
  endfunction

  function automatic logic [2:0] drop_top(logic [2:0] v);
    for (int k = 2; k >= 0; k--) begin
      if (v[k]) begin
        v[k] = 1'b0;
        return v;
      end
    end
    return v;
  endfunction

  task automatic model_reset();
    m_n    = 0;
    m_smp.delete();
    m_mode = 0;
    m_cont = 0;
    m_out  = 3'b000;
    m_busy = 1'b0;
    m_due  = 0;
  endtask

  task automatic model_step();
    bit         req;
    int         ck;
    logic [2:0] tmp;
    if (iRST) begin
      model_reset();
      return;
    end
    m_n++;
    m_smp.push_back(iSOFT_REQ);
    req = smp_at(m_n - 2) && !smp_at(m_n - 3);
    ck = -1;
    for (int k = 0; k < 3; k++) if (thr[k] == m_cont) ck = k;
    case (m_mode)
      0: begin
        if (m_n >= 3) begin
          m_mode = 1;
          m_cont = 1;
        end
      end
      1: begin
        if (req) begin
          tmp = m_out;
          if (ck >= 0) tmp[ck] = 1'b1;
          m_out  = drop_top(tmp);
          m_mode = 3;
          m_busy = 1'b1;
          m_due  = m_n + G;
        end else begin
          if (ck >= 0) m_out[ck] = 1'b1;
          if (m_cont < thr[2]) m_cont++;
          if (m_out == 3'b111) m_mode = 2;
        end
      end
      2: begin
        if (req) begin
          m_out  = drop_top(m_out);
          m_mode = 3;
          m_busy = 1'b1;
          m_due  = m_n + G;
        end
      end
      default: begin
        if (m_n == m_due) begin
          if (m_out != 3'b000) begin
            m_out = drop_top(m_out);
            m_due = m_n + G;
          end else begin
            m_mode = 1;
            m_cont = 0;
            m_busy = 1'b0;
          end
        end
      end
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", tag, got, exp, m_n, $time);
    end
  endtask

  task automatic check_all();
    check_val("rst_n", int'(oRST_N), int'(m_out));
    check_val("done",  int'(oDONE),  int'(m_out == 3'b111));
    check_val("busy",  int'(oBUSY),  int'(m_busy));
    check_val("cont",  int'(dut.r_cont), m_cont);
  endtask

  // One clock edge: advance the model, then compare just after the edge.
  task automatic tick();
    @(posedge iCLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Short asynchronous reset pulse between edges.
  task automatic pulse_rst();
    iRST = 1'b1;
    #0.5;
    model_reset();
    check_val("pulse_rst_n", int'(oRST_N), 0);
    check_val("pulse_busy",  int'(oBUSY),  0);
    #0.5;
    iRST = 1'b0;
  endtask

  task automatic restart();
    iRST      = 1'b1;
    iSOFT_REQ = 1'b0;
    ticks(2);
    iRST = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    iRST      = 1'b1;
    iSOFT_REQ = 1'b0;
    model_reset();

    // Reset state, with request toggling while held in reset.
    ticks(2);
    iSOFT_REQ = 1'b1;
    ticks(2);
    check_val("reset_rst_n", int'(oRST_N), 0);
    check_val("reset_done",  int'(oDONE),  0);
    restart();

    // Basic release ramp with fixed-timing spot checks.
    for (int e = 1; e <= 40; e++) begin
      tick();
      if (e == 6)  check_val("t1_e6",  int'(oRST_N), 0);
      if (e == 7)  check_val("t1_e7",  int'(oRST_N), 1);
      if (e == 10) check_val("t1_e10", int'(oRST_N), 1);
      if (e == 11) check_val("t1_e11", int'(oRST_N), 3);
      if (e == 22) check_val("t1_e22", int'(oDONE),  0);
      if (e == 23) check_val("t1_e23", int'(oRST_N), 7);
      if (e == 40) check_val("t1_cont40", int'(dut.r_cont), 20);
    end

    // Async reset pulse mid-ramp, then full restart timing.
    restart();
    ticks(9);
    pulse_rst();
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 7)  check_val("t2_e7",  int'(oRST_N), 1);
      if (e == 23) check_val("t2_e23", int'(oRST_N), 7);
    end

    // Soft request in RUN; E is the third edge after the rise.
    restart();
    ticks(30);
    iSOFT_REQ = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (e == 3)  check_val("t3_E",    int'(oRST_N), 3);
      if (e == 6)  check_val("t3_E3",   int'(oRST_N), 1);
      if (e == 9)  check_val("t3_E6",   int'(oRST_N), 0);
      if (e == 11) check_val("t3_E8b",  int'(oBUSY),  1);
      if (e == 12) check_val("t3_E9b",  int'(oBUSY),  0);
    end
    iSOFT_REQ = 1'b0;
    ticks(10);

    // Second rise during shutdown, level held through completion.
    restart();
    ticks(26);
    iSOFT_REQ = 1'b1;
    ticks(5);
    iSOFT_REQ = 1'b0;
    tick();
    iSOFT_REQ = 1'b1;
    ticks(40);
    iSOFT_REQ = 1'b0;
    ticks(5);

    // Request with only output 0 released.
    restart();
    ticks(6);
    iSOFT_REQ = 1'b1;
    ticks(12);
    iSOFT_REQ = 1'b0;
    ticks(30);

    // Request before any output is released.
    restart();
    ticks(2);
    iSOFT_REQ = 1'b1;
    ticks(3);
    iSOFT_REQ = 1'b0;
    ticks(20);

    // Request edge coincident with the output 1 crossing.
    restart();
    ticks(8);
    iSOFT_REQ = 1'b1;
    ticks(3);
    check_val("t6_E", int'(oRST_N), 1);
    ticks(3);
    check_val("t6_E3", int'(oRST_N), 0);
    iSOFT_REQ = 1'b0;
    ticks(30);

    // Randomized soak.
    restart();
    for (int i = 0; i < 2500; i++) begin
      int r;
      tick();
      r = $urandom_range(0, 199);
      if (r < 6) iSOFT_REQ = ~iSOFT_REQ;
      if (r == 199) pulse_rst();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
